// File: rtl/qeciphy_loopback_responder.sv
// Far-end loopback responder: echoes the QECIPHY RX stream onto TX (optionally XOR-masked)
// through an elastic FIFO that absorbs TX_TREADY stalls; RX cannot stall, so overflow drops beats.
module qeciphy_loopback_responder #(
    parameter int                DATA_W     = 64,
    parameter int                FIFO_DEPTH = 16,
    parameter logic [DATA_W-1:0] XOR_MASK   = '0
) (
    input  logic                            ACLK,
    input  logic                            rst_n,
    input  logic                            enable,
    input  logic                            link_up,
    input  logic                            clear_stats,
    input  logic [DATA_W-1:0]               rx_tdata,
    input  logic                            rx_tvalid,
    output logic                            rx_tready,
    output logic [DATA_W-1:0]               tx_tdata,
    output logic                            tx_tvalid,
    input  logic                            tx_tready,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            overflow,
    output logic [15:0]                     drop_count,
    output logic [31:0]                     echo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic                overflow_q, overflow_d;
    logic [15:0]         drop_count_q, drop_count_d;
    logic [31:0]         echo_count_q, echo_count_d;
    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];

    logic                run;
    logic                flush;
    logic                empty;
    logic                full;
    logic                push;
    logic                pop;
    logic                drop;

    // State register
    always_ff @(posedge ACLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable && link_up)    state_d = RUN;
            RUN:     if (!enable || !link_up)  state_d = FLUSH;
            FLUSH:                             state_d = IDLE;
            default:                           state_d = IDLE;
        endcase
    end

    // State decode
    always_comb begin
        run   = (state_q == RUN);
        flush = (state_q == FLUSH);
    end

    // FIFO status and handshake qualification
    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        tx_tvalid = run && !empty;
        pop   = tx_tvalid && tx_tready;
        push  = run && rx_tvalid && (!full || pop);
        drop  = run && rx_tvalid && full && !pop;
    end

    // Pointer and statistics next values; a clear wins over a coincident increment
    always_comb begin
        wr_ptr_d = flush ? '0 : wr_ptr_q + PW'(push);
        rd_ptr_d = flush ? '0 : rd_ptr_q + PW'(pop);

        overflow_d   = overflow_q | drop;
        drop_count_d = drop_count_q;
        if (drop && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
        echo_count_d = echo_count_q + 32'(pop);

        if (clear_stats) begin
            overflow_d   = 1'b0;
            drop_count_d = '0;
            echo_count_d = '0;
        end
    end

    always_ff @(posedge ACLK or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
            echo_count_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
            echo_count_q <= echo_count_d;
        end
    end

    // Storage holds data only; validity is carried entirely by the pointers
    always_ff @(posedge ACLK) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= rx_tdata;
        end
    end

    // Outputs: first-word-fall-through head, forced to zero when not valid
    always_comb begin
        rx_tready  = 1'b1;
        tx_tdata   = tx_tvalid ? (mem_q[rd_ptr_q[AW-1:0]] ^ XOR_MASK) : '0;
        fifo_level = wr_ptr_q - rd_ptr_q;
        overflow   = overflow_q;
        drop_count = drop_count_q;
        echo_count = echo_count_q;
    end

endmodule

// File: tb/tb_qeciphy_loopback_responder.sv
// Scoreboard bench for qeciphy_loopback_responder: directed stimulus pushes expected echoes,
// a negedge monitor pops and compares on every TX handshake.
module tb_qeciphy_loopback_responder;

    localparam int          DATA_W = 64;
    localparam int          DEPTH  = 16;
    localparam logic [63:0] MASK   = 64'hFFFF_0000_FFFF_0000;

    logic        ACLK = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        link_up;
    logic        clear_stats;
    logic [63:0] rx_tdata;
    logic        rx_tvalid;
    logic        rx_tready;
    logic [63:0] tx_tdata;
    logic        tx_tvalid;
    logic        tx_tready;
    logic [4:0]  fifo_level;
    logic        overflow;
    logic [15:0] drop_count;
    logic [31:0] echo_count;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] sb [$];

    qeciphy_loopback_responder #(
        .DATA_W    (DATA_W),
        .FIFO_DEPTH(DEPTH),
        .XOR_MASK  (MASK)
    ) dut (
        .ACLK       (ACLK),
        .rst_n      (rst_n),
        .enable     (enable),
        .link_up    (link_up),
        .clear_stats(clear_stats),
        .rx_tdata   (rx_tdata),
        .rx_tvalid  (rx_tvalid),
        .rx_tready  (rx_tready),
        .tx_tdata   (tx_tdata),
        .tx_tvalid  (tx_tvalid),
        .tx_tready  (tx_tready),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .drop_count (drop_count),
        .echo_count (echo_count)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Monitor: a handshake seen at negedge completes on the following posedge
    always @(negedge ACLK) begin
        if (rst_n && tx_tvalid && tx_tready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_tx: got %h, expected no beat", tx_tdata);
            end else begin
                check("tx_data", tx_tdata, sb.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        enable      = 1'b0;
        link_up     = 1'b0;
        clear_stats = 1'b0;
        rx_tdata    = '0;
        rx_tvalid   = 1'b0;
        tx_tready   = 1'b0;
        repeat (3) tick();

        check("rst_tx_tvalid",  64'(tx_tvalid),  64'd0);
        check("rst_tx_tdata",   tx_tdata,        64'd0);
        check("rst_fifo_level", 64'(fifo_level), 64'd0);
        check("rst_overflow",   64'(overflow),   64'd0);
        check("rst_drop_count", 64'(drop_count), 64'd0);
        check("rst_echo_count", 64'(echo_count), 64'd0);
        check("rst_rx_tready",  64'(rx_tready),  64'd1);
        rst_n = 1'b1;
        tick();

        // Streaming echo of 1000 consecutive beats
        enable    = 1'b1;
        link_up   = 1'b1;
        tick();
        tx_tready = 1'b1;
        check("pre_latency_tvalid", 64'(tx_tvalid), 64'd0);
        for (int i = 0; i < 1000; i++) begin
            rx_tdata  = 64'(i);
            rx_tvalid = 1'b1;
            sb.push_back(64'(i) ^ MASK);
            tick();
            if (i == 0) begin
                check("latency_tvalid", 64'(tx_tvalid), 64'd1);
                check("latency_tdata",  tx_tdata,       64'hFFFF_0000_FFFF_0000);
            end
        end
        rx_tvalid = 1'b0;
        repeat (2) tick();
        check("stream_echo_count", 64'(echo_count), 64'd1000);
        check("stream_drop_count", 64'(drop_count), 64'd0);
        check("stream_level",      64'(fifo_level), 64'd0);

        // XOR mask on a single beat, held until released
        tx_tready = 1'b0;
        rx_tdata  = 64'h1;
        rx_tvalid = 1'b1;
        sb.push_back(64'hFFFF_0000_FFFF_0001);
        tick();
        rx_tvalid = 1'b0;
        check("xor_tdata", tx_tdata, 64'hFFFF_0000_FFFF_0001);
        tick();
        check("xor_hold_tdata", tx_tdata, 64'hFFFF_0000_FFFF_0001);
        tx_tready = 1'b1;
        tick();

        // Overflow: 20 beats into a stalled 16-deep FIFO
        tx_tready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rx_tdata  = 64'(100 + i);
            rx_tvalid = 1'b1;
            if (i < DEPTH) sb.push_back(64'(100 + i) ^ MASK);
            tick();
        end
        rx_tvalid = 1'b0;
        check("ovf_level",      64'(fifo_level), 64'd16);
        check("ovf_drop_count", 64'(drop_count), 64'd4);
        check("ovf_overflow",   64'(overflow),   64'd1);

        // Full FIFO with simultaneous push and pop
        rx_tdata  = 64'd200;
        rx_tvalid = 1'b1;
        tx_tready = 1'b1;
        sb.push_back(64'd200 ^ MASK);
        tick();
        rx_tvalid = 1'b0;
        check("full_pp_level", 64'(fifo_level), 64'd16);
        check("full_pp_drops", 64'(drop_count), 64'd4);
        for (int k = 0; k < 40 && fifo_level != 0; k++) tick();
        tick();
        check("drain_level",      64'(fifo_level), 64'd0);
        check("drain_echo_count", 64'(echo_count), 64'd1018);

        // Link loss with 5 beats queued
        tx_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rx_tdata  = 64'(300 + i);
            rx_tvalid = 1'b1;
            tick();
        end
        rx_tvalid = 1'b0;
        check("queued_level", 64'(fifo_level), 64'd5);
        link_up = 1'b0;
        tick();
        check("linkdown_tvalid", 64'(tx_tvalid), 64'd0);
        check("linkdown_tdata",  tx_tdata,       64'd0);
        tick();
        check("flush_level",      64'(fifo_level), 64'd0);
        check("flush_echo_count", 64'(echo_count), 64'd1018);
        check("flush_overflow",   64'(overflow),   64'd1);

        // Beats arriving in IDLE are ignored
        rx_tvalid = 1'b1;
        repeat (3) tick();
        rx_tvalid = 1'b0;
        check("idle_level",      64'(fifo_level), 64'd0);
        check("idle_drop_count", 64'(drop_count), 64'd4);

        // clear_stats coincident with a pop
        link_up = 1'b1;
        tick();
        rx_tdata  = 64'h55;
        rx_tvalid = 1'b1;
        sb.push_back(64'h55 ^ MASK);
        tick();
        rx_tvalid   = 1'b0;
        tx_tready   = 1'b1;
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        check("clr_echo_count", 64'(echo_count), 64'd0);
        check("clr_drop_count", 64'(drop_count), 64'd0);
        check("clr_overflow",   64'(overflow),   64'd0);
        check("clr_rx_tready",  64'(rx_tready),  64'd1);
        check("clr_level",      64'(fifo_level), 64'd0);

        tick();
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
